mby_wm_pkt_assembler: RTL

Egress-side packet assembler for the MBY white-model co-simulation path. It accepts the DUT's egress flit stream (valid/ready, sop/eop), packs the bytes into a single-packet buffer, and records the length and egress port. It then presents the completed packet to the testbench drain side, which reads it word by word and hands it to the white-model packet-push DPI call for comparison. It is the RTL counterpart to the DPI-side packet record (data bytes, 32-bit length, 16-bit port).

---
 rtl/mby_wm_pkt_assembler.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/mby_wm_pkt_assembler.sv
// -----------------------------------------------------------------------------
// mby_wm_pkt_assembler
//
// Egress-side packet assembler for the MBY white-model co-simulation path.
// Collects one packet from the DUT egress flit stream into a single-packet
// buffer and records its byte length and egress port. The completed packet is
// held until the drain side has read it out and signals pkt_done.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid / in_ready        egress flit handshake (transfer on both high)
//   in_data                    flit payload, byte 0 = bits[7:0] = lowest address
//   in_sop / in_eop            packet delimiters
//   in_bytes_vld               valid bytes in the eop flit (0 or >BYTES => BYTES)
//   in_port                    egress port, sampled on the sop flit
//   pkt_avail                  a complete packet is held and may be drained
//   pkt_len / pkt_port         byte length and port of the held packet
//   rd_addr / rd_data          buffer word read port, 1-cycle registered latency
//   pkt_done                   drain finished, releases the buffer
//   err_nosop                  pulse: non-sop flit accepted while idle
//   err_noeop                  pulse: sop arrived mid-packet (packet restarted)
//   err_trunc                  pulse: packet exceeded MAX_PKT_LEN and is dropped
//   pkt_cnt / drop_cnt         delivered / dropped packet counters (wrapping)
// -----------------------------------------------------------------------------
module mby_wm_pkt_assembler #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned MAX_PKT_LEN = 16384,
    parameter int unsigned PORT_W      = 16
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [DATA_W-1:0]                              in_data,
    input  logic                                           in_sop,
    input  logic                                           in_eop,
    input  logic [3:0]                                     in_bytes_vld,
    input  logic [PORT_W-1:0]                              in_port,
    output logic                                           pkt_avail,
    output logic [31:0]                                    pkt_len,
    output logic [PORT_W-1:0]                              pkt_port,
    input  logic [$clog2(MAX_PKT_LEN/(DATA_W/8))-1:0]      rd_addr,
    output logic [DATA_W-1:0]                              rd_data,
    input  logic                                           pkt_done,
    output logic                                           err_nosop,
    output logic                                           err_noeop,
    output logic                                           err_trunc,
    output logic [31:0]                                    pkt_cnt,
    output logic [31:0]                                    drop_cnt
);

    localparam int unsigned BYTES   = DATA_W / 8;
    localparam int unsigned DEPTH   = MAX_PKT_LEN / BYTES;
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [31:0] BYTES_W = 32'(BYTES);
    localparam logic [31:0] MAX_W   = 32'(MAX_PKT_LEN);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSEMBLE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_DROP     = 2'd3
    } state_t;

    // Byte count contributed by an eop flit; out-of-range encodings mean a full flit.
    function automatic logic [31:0] norm_eop_bytes(input logic [3:0] bv);
        logic [31:0] v;
        v = {28'd0, bv};
        if ((v == 32'd0) || (v > BYTES_W)) begin
            return BYTES_W;
        end else begin
            return v;
        end
    endfunction

    state_t              state_r;
    logic [31:0]         byte_cnt_r;
    logic [AW-1:0]       wr_ptr_r;
    logic [PORT_W-1:0]   cur_port_r;
    logic [DATA_W-1:0]   pkt_mem [DEPTH];

    logic                xfer_s;
    logic                accept_pkt_s;
    logic                over_s;
    logic [31:0]         base_cnt_s;
    logic [31:0]         add_s;
    logic [31:0]         sum_s;
    logic [AW-1:0]       base_ptr_s;
    logic [PORT_W-1:0]   port_s;

    // Flit decode: where it lands, what the count becomes and whether it overflows.
    always_comb begin
        xfer_s       = in_valid & in_ready;
        base_cnt_s   = 32'd0;
        base_ptr_s   = PTR_ZERO;
        add_s        = BYTES_W;
        over_s       = 1'b0;
        port_s       = cur_port_r;
        accept_pkt_s = 1'b0;

        // sop always restarts at word 0, whatever state we were in
        if (in_sop) begin
            base_cnt_s = 32'd0;
            base_ptr_s = PTR_ZERO;
            port_s     = in_port;
        end else begin
            base_cnt_s = byte_cnt_r;
            base_ptr_s = wr_ptr_r;
            port_s     = cur_port_r;
        end

        if (in_eop) begin
            add_s = norm_eop_bytes(in_bytes_vld);
        end else begin
            add_s = BYTES_W;
        end

        sum_s = base_cnt_s + add_s;

        // A non-eop flit that fills the buffer leaves no room for the eop,
        // so it already counts as an overflow; an eop may land exactly on MAX.
        if (in_eop) begin
            over_s = (sum_s > MAX_W);
        end else begin
            over_s = (sum_s >= MAX_W);
        end

        // Flits that belong to a packet being stored (as opposed to discarded)
        case (state_r)
            ST_IDLE:     accept_pkt_s = xfer_s & in_sop;
            ST_ASSEMBLE: accept_pkt_s = xfer_s;
            ST_DROP:     accept_pkt_s = xfer_s & in_sop;
            default:     accept_pkt_s = 1'b0;
        endcase
    end

    // Packet buffer write; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept_pkt_s) begin
            pkt_mem[base_ptr_s] <= in_data;
        end
    end

    // Registered read port; a same-cycle write to rd_addr returns the old word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= {DATA_W{1'b0}};
        end else begin
            rd_data <= pkt_mem[rd_addr];
        end
    end

    // Assembler FSM with registered handshake, status, error and counter outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            byte_cnt_r <= 32'd0;
            wr_ptr_r   <= PTR_ZERO;
            cur_port_r <= {PORT_W{1'b0}};
            in_ready   <= 1'b1;
            pkt_avail  <= 1'b0;
            pkt_len    <= 32'd0;
            pkt_port   <= {PORT_W{1'b0}};
            err_nosop  <= 1'b0;
            err_noeop  <= 1'b0;
            err_trunc  <= 1'b0;
            pkt_cnt    <= 32'd0;
            drop_cnt   <= 32'd0;
        end else begin
            err_nosop <= 1'b0;
            err_noeop <= 1'b0;
            err_trunc <= 1'b0;

            if (accept_pkt_s) begin
                if (in_sop) begin
                    cur_port_r <= in_port;
                end
                // A restart from DROP is expected, only a restart mid-assembly is an error
                if ((state_r == ST_ASSEMBLE) && in_sop) begin
                    err_noeop <= 1'b1;
                end
                if (over_s) begin
                    err_trunc <= 1'b1;
                    drop_cnt  <= drop_cnt + 32'd1;
                    state_r   <= in_eop ? ST_IDLE : ST_DROP;
                end else begin
                    byte_cnt_r <= sum_s;
                    wr_ptr_r   <= base_ptr_s + PTR_ONE;
                    if (in_eop) begin
                        state_r   <= ST_HOLD;
                        in_ready  <= 1'b0;
                        pkt_avail <= 1'b1;
                        pkt_len   <= sum_s;
                        pkt_port  <= port_s;
                    end else begin
                        state_r <= ST_ASSEMBLE;
                    end
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        // Any transfer reaching here lacked sop and is discarded
                        if (xfer_s) begin
                            err_nosop <= 1'b1;
                        end
                    end
                    ST_ASSEMBLE: begin
                        // Every ASSEMBLE transfer is handled as a stored flit above
                    end
                    ST_HOLD: begin
                        if (pkt_done) begin
                            state_r   <= ST_IDLE;
                            pkt_avail <= 1'b0;
                            in_ready  <= 1'b1;
                            pkt_cnt   <= pkt_cnt + 32'd1;
                        end
                    end
                    ST_DROP: begin
                        if (xfer_s && in_eop) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        in_ready  <= 1'b1;
                        pkt_avail <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
